// File: rtl/hash_probe_counter_pkg.sv
// Shared constants and FSM encoding for the hashed frequency-counter cores.
package hash_probe_counter_pkg;

    localparam int DEF_DATA_INDEX_WIDTH = 32;
    localparam int DEF_BIT_ON_TAILS     = 7;
    localparam int DEF_COUNT_WIDTH      = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PROBE  = 3'd1,
        INSERT = 3'd2,
        INCR   = 3'd3,
        REPORT = 3'd4,
        CLEAR  = 3'd5
    } hpcState_e;

    function automatic int tableDepth(input int bits);
        return 1 << bits;
    endfunction

    // Hash mask: the low 'bits' bits of the data word select the home slot.
    function automatic longint unsigned hashMask(input int bits);
        return longint'(tableDepth(bits)) - 1;
    endfunction

endpackage

// File: rtl/hash_probe_counter_inc_modulus.sv
// Modulo incrementer: steps an index by one and wraps to zero after MODULUS-1.
module IncModulus #(
    parameter int WIDTH   = 7,
    parameter int MODULUS = 128
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] incremented
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign incremented = (value == LAST) ? '0 : value + WIDTH'(1);

endmodule

// File: rtl/hash_probe_counter.sv
// Open-addressed hash table of word frequencies with linear probing,
// one probe per cycle, and a slot-by-slot clear sequence.
module hash_probe_counter
    import hash_probe_counter_pkg::*;
#(
    parameter int DATA_INDEX_WIDTH = DEF_DATA_INDEX_WIDTH,
    parameter int BIT_ON_TAILS     = DEF_BIT_ON_TAILS,
    parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_INDEX_WIDTH-1:0] in_data,
    input  logic                        clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BIT_ON_TAILS-1:0]     out_index,
    output logic [COUNT_WIDTH-1:0]      out_count,
    output logic                        out_new,
    output logic                        out_full,
    output logic                        busy
);

    localparam int DEPTH = tableDepth(BIT_ON_TAILS);
    localparam logic [DATA_INDEX_WIDTH-1:0] MASK = DATA_INDEX_WIDTH'(hashMask(BIT_ON_TAILS));
    localparam logic [BIT_ON_TAILS:0] PROBE_LIMIT = (BIT_ON_TAILS+1)'(DEPTH);
    localparam logic [BIT_ON_TAILS:0] CLEAR_LAST  = (BIT_ON_TAILS+1)'(DEPTH - 1);

    hpcState_e                   state;
    logic [DATA_INDEX_WIDTH-1:0] dataReg;
    logic [BIT_ON_TAILS-1:0]     idx;
    logic [BIT_ON_TAILS-1:0]     idxNext;
    logic [BIT_ON_TAILS:0]       probeCnt;

    logic [DEPTH-1:0]            slotValid;
    logic [DATA_INDEX_WIDTH-1:0] slotKey   [DEPTH];
    logic [COUNT_WIDTH-1:0]      slotCount [DEPTH];

    logic                        slotHit;
    logic [COUNT_WIDTH-1:0]      bumpedCount;
    logic [DATA_INDEX_WIDTH-1:0] hashedData;

    IncModulus #(
        .WIDTH   (BIT_ON_TAILS),
        .MODULUS (DEPTH)
    ) uIncModulus (
        .value       (idx),
        .incremented (idxNext)
    );

    assign hashedData  = in_data & MASK;
    assign slotHit     = slotValid[idx] && (slotKey[idx] == dataReg);
    assign bumpedCount = (&slotCount[idx]) ? slotCount[idx] : slotCount[idx] + COUNT_WIDTH'(1);
    assign in_ready    = (state == IDLE) && !clear;
    assign busy        = (state != IDLE);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            dataReg   <= '0;
            idx       <= '0;
            probeCnt  <= '0;
            slotValid <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_count <= '0;
            out_new   <= 1'b0;
            out_full  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        idx      <= '0;
                        probeCnt <= '0;
                        state    <= CLEAR;
                    end else if (in_valid) begin
                        dataReg  <= in_data;
                        idx      <= hashedData[BIT_ON_TAILS-1:0];
                        probeCnt <= '0;
                        state    <= PROBE;
                    end
                end
                PROBE: begin
                    // Every slot visited without a match or hole: drop the key.
                    if (probeCnt == PROBE_LIMIT) begin
                        out_index <= idx;
                        out_count <= '0;
                        out_new   <= 1'b0;
                        out_full  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= REPORT;
                    end else if (slotHit) begin
                        state <= INCR;
                    end else if (!slotValid[idx]) begin
                        state <= INSERT;
                    end else begin
                        idx      <= idxNext;
                        probeCnt <= probeCnt + 1'b1;
                    end
                end
                INSERT: begin
                    slotValid[idx] <= 1'b1;
                    out_index      <= idx;
                    out_count      <= COUNT_WIDTH'(1);
                    out_new        <= 1'b1;
                    out_full       <= 1'b0;
                    out_valid      <= 1'b1;
                    state          <= REPORT;
                end
                INCR: begin
                    out_index <= idx;
                    out_count <= bumpedCount;
                    out_new   <= 1'b0;
                    out_full  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= REPORT;
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                CLEAR: begin
                    slotValid[idx] <= 1'b0;
                    idx            <= idxNext;
                    probeCnt       <= probeCnt + 1'b1;
                    if (probeCnt == CLEAR_LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Keys and counts are qualified by slotValid, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (state == INSERT) begin
            slotKey[idx]   <= dataReg;
            slotCount[idx] <= COUNT_WIDTH'(1);
        end else if (state == INCR) begin
            slotCount[idx] <= bumpedCount;
        end
    end

endmodule

// File: tb/tb_hash_probe_counter.sv
// Randomized bench for hash_probe_counter against an array-based table model.
module tb_hash_probe_counter;

    localparam int DW    = 32;
    localparam int BT    = 7;
    localparam int CW    = 16;
    localparam int DEPTH = 1 << BT;

    logic          CLK = 1'b0;
    logic          RESETN;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [BT-1:0] out_index;
    logic [CW-1:0] out_count;
    logic          out_new;
    logic          out_full;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    bit          mValid [DEPTH];
    logic [31:0] mKey   [DEPTH];
    int          mCount [DEPTH];

    int lastIdx, lastCnt;

    hash_probe_counter #(
        .DATA_INDEX_WIDTH (DW),
        .BIT_ON_TAILS     (BT),
        .COUNT_WIDTH      (CW)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_count (out_count),
        .out_new   (out_new),
        .out_full  (out_full),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void modelClear();
        for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
    endfunction

    function automatic bit modelHas(input logic [31:0] d);
        for (int i = 0; i < DEPTH; i++) if (mValid[i] && mKey[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    // Offer one word, check result/latency against the model, then drain it.
    task automatic applyWord(input logic [31:0] d);
        int  home, slot, probes, expCnt, lat, hold;
        bit  found, expNew, expFull;
        home = int'(d % DEPTH);
        found = 0; expNew = 0; expFull = 1; slot = home; probes = 0; expCnt = 0;
        for (int p = 0; p < DEPTH && !found; p++) begin
            slot = (home + p) % DEPTH;
            if (!mValid[slot]) begin
                found = 1; expNew = 1; expFull = 0; probes = p + 1; expCnt = 1;
            end else if (mKey[slot] == d) begin
                found = 1; expFull = 0; probes = p + 1;
                expCnt = (mCount[slot] >= (1 << CW) - 1) ? mCount[slot] : mCount[slot] + 1;
            end
        end
        if (!found) slot = home;

        chk("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge CLK);
        while (!out_valid && lat < 400) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        if (!out_valid) begin
            chk("result_timeout", out_valid, 1'b1);
            return;
        end
        chk("out_index", out_index, slot);
        chk("out_count", out_count, expCnt);
        chk("out_new", out_new, expNew);
        chk("out_full", out_full, expFull);
        if (!expFull) chk("latency", lat, probes + 2);
        lastIdx = int'(out_index);
        lastCnt = int'(out_count);

        hold = $urandom_range(0, 3);
        repeat (hold) begin
            @(negedge CLK);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_count", out_count, expCnt);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1 out_ready = 1'b0;
        @(negedge CLK);
        chk("valid_drop", out_valid, 1'b0);

        if (found) begin
            mValid[slot] = 1'b1;
            mKey[slot]   = d;
            mCount[slot] = expCnt;
        end
    endtask

    task automatic doClear();
        int cnt;
        clear = 1'b1;
        @(posedge CLK);
        #1 clear = 1'b0;
        cnt = 0;
        @(negedge CLK);
        while (busy && cnt < 400) begin
            cnt++;
            @(negedge CLK);
        end
        chk("clear_busy_cycles", cnt, DEPTH);
        modelClear();
    endtask

    initial begin
        logic [31:0] d;
        RESETN = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
        modelClear();
        repeat (3) @(negedge CLK);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_new", out_new, 1'b0);
        chk("rst_out_full", out_full, 1'b0);
        RESETN = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", in_ready, 1'b1);

        // Directed: insert, hit, one-step probe, wrap-around probe.
        applyWord(32'h0000_0105);
        chk("first_idx", lastIdx, 5);
        chk("first_cnt", lastCnt, 1);
        applyWord(32'h0000_0105);
        chk("hit_cnt", lastCnt, 2);
        doClear();
        applyWord(32'h05);
        applyWord(32'h85);
        chk("collide_idx", lastIdx, 6);
        applyWord(32'h7F);
        applyWord(32'hFF);
        chk("wrap_idx", lastIdx, 0);

        // Fill the table, overflow it, and confirm nothing was disturbed.
        doClear();
        for (int i = 0; i < DEPTH; i++) begin
            d = 32'(i) | (32'($urandom_range(0, 7)) << 7);
            applyWord(d);
        end
        applyWord(32'h0001_2345);
        chk("full_cnt", lastCnt, 0);
        applyWord(mKey[3]);
        chk("after_full_hit", lastCnt, 2);
        doClear();
        applyWord(32'h05);
        chk("post_clear_cnt", lastCnt, 1);

        // Random mix over a small key pool to exercise collisions and hits.
        doClear();
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 39) == 0) doClear();
            d = (32'($urandom_range(0, 5)) << 7) | 32'($urandom_range(0, 15));
            applyWord(d);
        end

        // Reset in the middle of a long probe.
        doClear();
        for (int i = 16; i < 32; i++) applyWord(32'(i));
        in_valid = 1'b1;
        in_data  = 32'h110;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2 RESETN = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_probe_valid", out_valid, 1'b0);
            chk("rst_probe_busy", busy, 1'b0);
        end
        RESETN = 1'b1;
        modelClear();
        @(negedge CLK);
        chk("rst_release_valid", out_valid, 1'b0);
        chk("rst_release_ready", in_ready, 1'b1);
        applyWord(32'h10);
        chk("reinsert_cnt", lastCnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
